// File: rtl/sd_ctrl_write.sv
// rtl/sd_ctrl_write.sv - FIFO-fed SD card sector write controller
//
// Drains a 16-bit data FIFO into the low-level SD sector writer one sector at
// a time, walking sector addresses from start_section to end_section
// (inclusive). A sector is only started once a whole sector of words is
// waiting in the FIFO and the writer is idle.
//
// Optional feature: define SD_WR_FLUSH_EN to let flush_req write out a final
// partial sector, padded with 0x0000. Without it flush_req is ignored and a
// partial tail stays in the FIFO.
//
// Ports:
//   sd_clk         SD work clock (only clock)
//   rst            synchronous active-high reset
//   wr_enable      level; start and keep recording
//   start_section  first sector address, sampled when leaving IDLE
//   end_section    last sector address (inclusive), sampled when leaving IDLE
//   fifo_rd_count  words currently readable in the FIFO
//   fifo_rd_en     FIFO read strobe; data appears on fifo_rd_data one cycle later
//   fifo_rd_data   FIFO output word
//   sd_init_done   SD card initialised
//   wr_start_en    one-cycle pulse starting one sector write
//   wr_sec_addr    sector address of the write
//   wr_req         writer requests the next word
//   wr_data        registered word to the writer
//   wr_busy        writer busy
//   flush_req      pulse; flush the partial tail (SD_WR_FLUSH_EN only)
//   wr_done        level; address range finished or flush finished
module sd_ctrl_write #(
  parameter int WORDS_PER_SEC = 256,
  parameter int CNT_W         = 10
) (
  input  logic             sd_clk,
  input  logic             rst,
  input  logic             wr_enable,
  input  logic [31:0]      start_section,
  input  logic [31:0]      end_section,
  input  logic [CNT_W-1:0] fifo_rd_count,
  output logic             fifo_rd_en,
  input  logic [15:0]      fifo_rd_data,
  input  logic             sd_init_done,
  output logic             wr_start_en,
  output logic [31:0]      wr_sec_addr,
  input  logic             wr_req,
  output logic [15:0]      wr_data,
  input  logic             wr_busy,
  input  logic             flush_req,
  output logic             wr_done
);

  localparam int CW = $clog2(WORDS_PER_SEC + 1);
  localparam logic [CW-1:0]    SEC_WORDS     = CW'(WORDS_PER_SEC);
  localparam logic [CNT_W-1:0] SEC_WORDS_CNT = CNT_W'(WORDS_PER_SEC);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    START,
    BUSY,
    NEXT,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] end_sec;
  logic [CW-1:0] avail;     // words to take from the FIFO this sector
  logic [CW-1:0] word_cnt;  // writer requests seen this sector
  logic        busy_d0;
  logic        busy_d1;
  logic        rd_pending;  // FIFO word arrives on fifo_rd_data this cycle
  logic        req_d;       // a request was served last cycle
  logic        flush_act;   // current sector is a flush sector
  logic [32:0] next_addr;
  logic        busy_fall;
  logic        take_word;

  // 33-bit increment so end_section = 0xFFFFFFFF finishes instead of wrapping.
  assign next_addr  = {1'b0, wr_sec_addr} + 33'd1;
  assign busy_fall  = busy_d1 & ~busy_d0;
  assign take_word  = (state == BUSY) && wr_req && (word_cnt < avail);
  assign fifo_rd_en = take_word;

`ifdef SD_WR_FLUSH_EN
  logic flush_pend;
  logic flush_now;
  assign flush_now = flush_req | flush_pend;
`else
  logic unused_flush;
  assign unused_flush = flush_req;
`endif

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_start_en <= 1'b0;
      wr_sec_addr <= '0;
      wr_data     <= '0;
      wr_done     <= 1'b0;
      end_sec     <= '0;
      avail       <= '0;
      word_cnt    <= '0;
      busy_d0     <= 1'b0;
      busy_d1     <= 1'b0;
      rd_pending  <= 1'b0;
      req_d       <= 1'b0;
      flush_act   <= 1'b0;
`ifdef SD_WR_FLUSH_EN
      flush_pend  <= 1'b0;
`endif
    end else begin
      busy_d0     <= wr_busy;
      busy_d1     <= busy_d0;
      rd_pending  <= take_word;
      req_d       <= (state == BUSY) && wr_req;
      wr_start_en <= 1'b0;

      // Served requests beyond avail get a zero word instead of FIFO data.
      if (rd_pending) begin
        wr_data <= fifo_rd_data;
      end else if (req_d) begin
        wr_data <= '0;
      end

`ifdef SD_WR_FLUSH_EN
      // A flush seen in any state is remembered until WAIT_DATA handles it.
      if (flush_req) begin
        flush_pend <= 1'b1;
      end
`endif

      case (state)
        IDLE: begin
          if (wr_enable && sd_init_done) begin
            wr_sec_addr <= start_section;
            end_sec     <= end_section;
            if (start_section > end_section) begin
              state   <= DONE;
              wr_done <= 1'b1;
            end else begin
              state <= WAIT_DATA;
            end
          end
        end

        WAIT_DATA: begin
          if (!wr_enable) begin
            state <= IDLE;
          end else if (fifo_rd_count >= SEC_WORDS_CNT && !wr_busy) begin
            avail       <= SEC_WORDS;
            flush_act   <= 1'b0;
            wr_start_en <= 1'b1;
            state       <= START;
          end
`ifdef SD_WR_FLUSH_EN
          else if (flush_now && fifo_rd_count == '0) begin
            flush_pend <= 1'b0;
            wr_done    <= 1'b1;
            state      <= DONE;
          end else if (flush_now && !wr_busy) begin
            flush_pend  <= 1'b0;
            avail       <= fifo_rd_count[CW-1:0];
            flush_act   <= 1'b1;
            wr_start_en <= 1'b1;
            state       <= START;
          end
`endif
        end

        START: begin
          word_cnt <= '0;
          state    <= BUSY;
        end

        BUSY: begin
          if (wr_req && word_cnt < SEC_WORDS) begin
            word_cnt <= word_cnt + CW'(1);
          end
          if (busy_fall) begin
            state <= NEXT;
          end
        end

        NEXT: begin
          wr_sec_addr <= next_addr[31:0];
          if (next_addr > {1'b0, end_sec} || flush_act) begin
            flush_act <= 1'b0;
            wr_done   <= 1'b1;
            state     <= DONE;
          end else if (wr_enable) begin
            state <= WAIT_DATA;
          end else begin
            state <= IDLE;
          end
        end

        DONE: begin
          if (!wr_enable) begin
            wr_done <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_ctrl_write.sv
// tb/tb_sd_ctrl_write.sv - scoreboard testbench for sd_ctrl_write
module tb_sd_ctrl_write;

  localparam int WPS   = 256;
  localparam int CNT_W = 10;

  logic             sd_clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_enable = 1'b0;
  logic [31:0]      start_section = '0;
  logic [31:0]      end_section = '0;
  logic [CNT_W-1:0] fifo_rd_count;
  logic             fifo_rd_en;
  logic [15:0]      fifo_rd_data = '0;
  logic             sd_init_done = 1'b0;
  logic             wr_start_en;
  logic [31:0]      wr_sec_addr;
  logic             wr_req = 1'b0;
  logic [15:0]      wr_data;
  logic             wr_busy = 1'b0;
  logic             flush_req = 1'b0;
  logic             wr_done;

  sd_ctrl_write #(.WORDS_PER_SEC(WPS), .CNT_W(CNT_W)) dut (
    .sd_clk        (sd_clk),
    .rst           (rst),
    .wr_enable     (wr_enable),
    .start_section (start_section),
    .end_section   (end_section),
    .fifo_rd_count (fifo_rd_count),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .sd_init_done  (sd_init_done),
    .wr_start_en   (wr_start_en),
    .wr_sec_addr   (wr_sec_addr),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_busy       (wr_busy),
    .flush_req     (flush_req),
    .wr_done       (wr_done)
  );

  always #5 sd_clk = ~sd_clk;

  // FIFO model: registered read, data valid the cycle after fifo_rd_en.
  logic [15:0] fifo_mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rd_count = CNT_W'(wr_ptr - rd_ptr);

  always @(posedge sd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fifo_mem[rd_ptr % 2048];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [15:0] w);
    fifo_mem[wr_ptr % 2048] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  // Scoreboard state
  logic [31:0] exp_addr [$];
  logic [15:0] exp_data [$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_start = 0;
  int n_rd = 0;
  bit data_chk = 1'b1;
  int n_req = WPS;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SD writer model: on a start pulse, go busy, request n_req words every
  // other cycle, then drop busy a few cycles later.
  initial begin
    forever begin
      @(negedge sd_clk);
      if (wr_start_en) begin
        @(posedge sd_clk); #1 wr_busy = 1'b1;
        for (int i = 0; i < n_req; i++) begin
          @(posedge sd_clk); #1 wr_req = 1'b1;
          @(posedge sd_clk); #1 wr_req = 1'b0;
        end
        repeat (4) @(posedge sd_clk);
        #1 wr_busy = 1'b0;
      end
    end
  end

  // Monitor: start pulses pop expected addresses; each writer request pops
  // an expected word at the writer's sample point two cycles later.
  initial begin
    logic rq1 = 1'b0;
    logic rq2 = 1'b0;
    forever begin
      @(negedge sd_clk);
      if (fifo_rd_en) n_rd++;
      if (wr_start_en) begin
        n_start++;
        if (exp_addr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_start: addr %h, none expected", wr_sec_addr);
        end else begin
          check("wr_sec_addr", wr_sec_addr, exp_addr.pop_front());
        end
      end
      if (rq2 && data_chk) begin
        if (exp_data.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: wr_data %h, none expected", wr_data);
        end else begin
          check("wr_data", {16'h0, wr_data}, {16'h0, exp_data.pop_front()});
        end
      end
      rq2 = rq1;
      rq1 = wr_req;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sd_clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int k = 0;
    while (wr_done !== 1'b1 && k < max_cyc) begin
      @(negedge sd_clk);
      k++;
    end
    check(name, {31'h0, wr_done}, 32'h1);
    step(1);
  endtask

  task automatic wait_busy(input string name, input logic lvl, input int max_cyc);
    int k = 0;
    while (wr_busy !== lvl && k < max_cyc) begin
      @(negedge sd_clk);
      k++;
    end
    check(name, {31'h0, wr_busy}, {31'h0, lvl});
    step(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fifo_rd_en"}, {31'h0, fifo_rd_en}, 32'h0);
    check({tag, "_wr_start_en"}, {31'h0, wr_start_en}, 32'h0);
    check({tag, "_wr_sec_addr"}, wr_sec_addr, 32'h0);
    check({tag, "_wr_data"}, {16'h0, wr_data}, 32'h0);
    check({tag, "_wr_done"}, {31'h0, wr_done}, 32'h0);
  endtask

  initial begin
    int s0;
    int r0;

    // Reset state
    repeat (3) @(posedge sd_clk);
    @(negedge sd_clk);
    check_reset_outputs("reset");
    step(1);
    rst = 1'b0;
    sd_init_done = 1'b1;

    // Range of two full sectors, 100..101, data 0..511
    for (int i = 0; i < 512; i++) begin
      push(16'(i));
      exp_data.push_back(16'(i));
    end
    exp_addr.push_back(32'd100);
    exp_addr.push_back(32'd101);
    start_section = 32'd100;
    end_section = 32'd101;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    wait_done("range_done", 3000);
    check("range_starts", n_start - s0, 2);
    check("range_reads", n_rd - r0, 512);
    check("range_words_left", exp_data.size(), 0);
    wr_enable = 1'b0;
    step(2);
    check("range_done_clear", {31'h0, wr_done}, 32'h0);

    // FIFO starvation: 255 words for 1000 cycles, then the 256th
    for (int i = 0; i < 255; i++) push(16'h1000 + 16'(i));
    start_section = 32'd200;
    end_section = 32'd200;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    step(1000);
    check("starve_no_start", n_start - s0, 0);
    exp_addr.push_back(32'd200);
    for (int i = 0; i < 256; i++) exp_data.push_back(16'h1000 + 16'(i));
    push(16'h1000 + 16'd255);
    @(negedge sd_clk);
    check("starve_start_early", {31'h0, wr_start_en}, 32'h0);
    @(negedge sd_clk);
    check("starve_start_edge", {31'h0, wr_start_en}, 32'h1);
    step(1);
    wait_done("starve_done", 1500);
    check("starve_reads", n_rd - r0, 256);
    wr_enable = 1'b0;
    step(2);

    // Empty range: start > end
    start_section = 32'd5;
    end_section = 32'd4;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    wait_done("empty_done", 20);
    check("empty_starts", n_start - s0, 0);
    check("empty_reads", n_rd - r0, 0);
    wr_enable = 1'b0;
    step(2);

    // Top-of-range address, with two extra writer requests past the sector
    n_req = WPS + 2;
    for (int i = 0; i < 256; i++) begin
      push(16'h5000 + 16'(i));
      exp_data.push_back(16'h5000 + 16'(i));
    end
    exp_data.push_back(16'h0000);
    exp_data.push_back(16'h0000);
    exp_addr.push_back(32'hFFFF_FFFF);
    start_section = 32'hFFFF_FFFF;
    end_section = 32'hFFFF_FFFF;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    wait_done("top_done", 1500);
    step(50);
    check("top_starts", n_start - s0, 1);
    check("top_reads", n_rd - r0, 256);
    check("top_words_left", exp_data.size(), 0);
    wr_enable = 1'b0;
    n_req = WPS;
    step(2);

`ifdef SD_WR_FLUSH_EN
    // Flush of a 100-word partial sector
    for (int i = 0; i < 100; i++) begin
      push(16'hA5A5);
      exp_data.push_back(16'hA5A5);
    end
    for (int i = 0; i < 156; i++) exp_data.push_back(16'h0000);
    exp_addr.push_back(32'd500);
    start_section = 32'd500;
    end_section = 32'd600;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    step(5);
    flush_req = 1'b1;
    step(1);
    flush_req = 1'b0;
    wait_done("flush_done", 1500);
    check("flush_starts", n_start - s0, 1);
    check("flush_reads", n_rd - r0, 100);
    check("flush_words_left", exp_data.size(), 0);
    wr_enable = 1'b0;
    step(2);
`endif

    // wr_enable dropped mid-sector: sector completes, address advances
    for (int i = 0; i < 256; i++) begin
      push(16'h6000 + 16'(i));
      exp_data.push_back(16'h6000 + 16'(i));
    end
    exp_addr.push_back(32'd300);
    start_section = 32'd300;
    end_section = 32'd310;
    s0 = n_start;
    r0 = n_rd;
    wr_enable = 1'b1;
    wait_busy("stop_busy_rise", 1'b1, 200);
    step(20);
    wr_enable = 1'b0;
    wait_busy("stop_busy_fall", 1'b0, 1000);
    step(10);
    check("stop_addr", wr_sec_addr, 32'd301);
    check("stop_no_done", {31'h0, wr_done}, 32'h0);
    check("stop_starts", n_start - s0, 1);
    check("stop_reads", n_rd - r0, 256);

    // Reset for one cycle during BUSY
    data_chk = 1'b0;
    for (int i = 0; i < 256; i++) push(16'h7000 + 16'(i));
    exp_addr.push_back(32'd400);
    start_section = 32'd400;
    end_section = 32'd401;
    wr_enable = 1'b1;
    wait_busy("rst_busy_rise", 1'b1, 200);
    step(20);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge sd_clk);
    check_reset_outputs("midrst");
    wr_enable = 1'b0;
    wait_busy("rst_busy_fall", 1'b0, 1000);
    check("rst_addr_left", exp_addr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_ctrl_write.md
# sd_ctrl_write

FIFO-fed SD card write controller: drains a 16-bit data FIFO one 512-byte sector at a time into the low-level SD sector writer, walking sector addresses from `start_section` to `end_section`. It sits between the capture/record FIFO and the SD write engine. It is the counterpart of the FIFO-interfaced SD read controller used in the audio playback path.

## Interface
- `WORDS_PER_SEC`, default 256: 16-bit words per sector.
- `CNT_W`, default 10: width of the FIFO read-side word count.

- `sd_clk`  in  1  SD work clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_enable`  in  1  level; start and keep recording.
- `start_section`  in  32  first sector address; sampled when leaving IDLE.
- `end_section`  in  32  last sector address, inclusive; sampled when leaving IDLE.
- `fifo_rd_count`  in  CNT_W  words currently readable in the FIFO.
- `fifo_rd_en`  out  1  FIFO read strobe; data appears on `fifo_rd_data` 1 cycle later.
- `fifo_rd_data`  in  16  FIFO output word.
- `sd_init_done`  in  1  SD card initialised.
- `wr_start_en`  out  1  one-cycle pulse; starts one sector write.
- `wr_sec_addr`  out  32  sector address for the write.
- `wr_req`  in  1  SD writer requests the next word; the writer samples `wr_data` 1 cycle later.
- `wr_data`  out  16  word to the SD writer.
- `wr_busy`  in  1  SD writer busy.
- `flush_req`  in  1  pulse; write out the final partial sector (macro only).
- `wr_done`  out  1  level; the address range is finished, or a flush is finished.

## Operation
- Reset values:
  - outputs: `fifo_rd_en`=0, `wr_start_en`=0, `wr_sec_addr`=0, `wr_data`=0, `wr_done`=0.
  - state: IDLE; `word_cnt`=0.
- State machine:
  - IDLE → WAIT_DATA when `wr_enable && sd_init_done`.
    - Load `wr_sec_addr` ← `start_section`; latch `end_section`.
    - If `start_section > end_section`, go directly to DONE; no write is issued.
  - WAIT_DATA → START when `fifo_rd_count >= WORDS_PER_SEC && !wr_busy`.
    - `avail` ← `WORDS_PER_SEC`.
    - → IDLE if `wr_enable` is low.
  - START: assert `wr_start_en` for 1 cycle; clear `word_cnt`; → BUSY.
  - BUSY:
    - `fifo_rd_en = wr_req && word_cnt < avail`.
    - `word_cnt` increments on each `wr_req` and saturates at `WORDS_PER_SEC`.
    - Exit on the `wr_busy` falling edge, detected via two registers as `busy_d1 & ~busy_d0`; → NEXT.
  - NEXT:
    - `wr_sec_addr` ← `wr_sec_addr + 1`. The comparison uses a 33-bit address, so `end_section` = 0xFFFFFFFF terminates correctly and does not wrap.
    - If `addr+1 > end_section` or a flush sector just completed → DONE.
    - Else if `wr_enable` → WAIT_DATA.
    - Else → IDLE.
  - DONE: `wr_done`=1; → IDLE when `wr_enable` falls. `wr_done` clears on leaving DONE.
- `wr_data` is registered: it carries `fifo_rd_data` for words with `word_cnt < avail`, else 0.
- Extra `wr_req` beyond `WORDS_PER_SEC` produces no FIFO read and `wr_data`=0.
- `wr_enable` deasserted mid-sector: the current sector completes, then the block returns to IDLE.
- `rst` mid-sector returns the block to IDLE at once. The SD writer is not aborted; the next start waits in WAIT_DATA for `!wr_busy`.

## Timing
- WAIT_DATA condition true at edge k: `wr_start_en` is high for cycle k+1 only, and `wr_sec_addr` is stable from k+1 until NEXT.
- `fifo_rd_en` is combinational from `wr_req`, in the same cycle. The FIFO data appears 1 cycle later and is registered into `wr_data`, so it aligns with the writer's sample point.
- `wr_busy` falling at edge j: NEXT is at j+2 and the next `wr_start_en` is at j+4 at the earliest.
- The sector address advances exactly once per completed sector; the FIFO is read exactly `avail` times per sector.

## Configuration
- `SD_WR_FLUSH_EN` defined: in WAIT_DATA, `flush_req` with `0 < fifo_rd_count < WORDS_PER_SEC`:
  - latches `avail` ← `fifo_rd_count`, marks a flush and goes to START;
  - words past `avail` are written as 0x0000;
  - after NEXT the block goes to DONE.
  - `flush_req` with `fifo_rd_count`=0 goes to DONE without writing.
  - `flush_req` outside WAIT_DATA is held pending until WAIT_DATA.
- Not defined: the `flush_req` port exists but is ignored. Only full sectors are written; a partial tail stays in the FIFO.

## Test plan
- Range, 2 full sectors: `start`=100, `end`=101, FIFO preloaded with 512 words (0..511).
  - Required: two `wr_start_en` pulses, with addr 100 then 101.
  - Required: `wr_data` sequence 0..511 in order, then `wr_done`=1 and exactly 512 `fifo_rd_en`.
- FIFO starvation: `fifo_rd_count`=255 for 1000 cycles, then 256.
  - Required: no `wr_start_en` while the count is 255; the pulse comes 2 cycles after the count reaches 256.
- Empty range: `start`=5, `end`=4.
  - Required: `wr_done` rises with no `wr_start_en` and no `fifo_rd_en`.
- Top-of-range address: `start`=`end`=0xFFFFFFFF.
  - Required: one write at 0xFFFFFFFF, then DONE; no second write at 0.
- Flush (`SD_WR_FLUSH_EN`): 100 words 0xA5A5 in the FIFO, `flush_req` pulsed.
  - Required: one sector; 100 words of 0xA5A5 followed by 156 words of 0x0000; 100 `fifo_rd_en`; then `wr_done`.
- Stop and reset mid-sector: `wr_enable` dropped during BUSY.
  - Required: the sector finishes and the block returns to IDLE with the address advanced.
  - Then `rst` high for 1 cycle during a later BUSY: all outputs return to their reset values on the next cycle.
